// File: rtl/frame_writer.sv
// rtl/frame_writer.sv - solver results to RGB332 framebuffer write beats with frame-done signalling
//
// Purpose: rebuilds the linear pixel index from (solver_id, solver_addr),
// maps the iteration count to a colour, drops out-of-frame beats, buffers
// in-frame pixels in a first-word-fall-through FIFO and pulses frame_done
// once the last pixel of a frame has left the block.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   result stream handshake
//   in_solver_id        solver index (6 bits)
//   in_solver_addr      per-solver slot index (19 bits)
//   in_iter             iteration count (ITER_W bits)
//   in_last             final beat of the frame
//   wr_valid/wr_ready   framebuffer write handshake
//   wr_addr, wr_data    pixel address and RGB332 colour (FIFO head)
//   frame_done          one-cycle pulse after the frame has fully drained
//   drop_count          saturating count of out-of-frame beats
//   pal_we/pal_addr/pal_data  palette write port (PALETTE_EN builds only)
//
// Optional feature macro: PALETTE_EN (16-entry writable colour palette).

module frame_writer #(
    parameter int NUM_SOLVERS = 7,
    parameter int NUM_COLUMNS = 99,
    parameter int NUM_ROWS    = 66,
    parameter int ITER_W      = 16,
    parameter int MAX_ITER    = 1000,
    parameter int FB_ADDR_W   = 19,
    parameter int FB_BASE     = 0,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [5:0]           in_solver_id,
    input  logic [18:0]          in_solver_addr,
    input  logic [ITER_W-1:0]    in_iter,
    input  logic                 in_last,
    output logic                 wr_valid,
    input  logic                 wr_ready,
    output logic [FB_ADDR_W-1:0] wr_addr,
    output logic [7:0]           wr_data,
    output logic                 frame_done,
    output logic [15:0]          drop_count
`ifdef PALETTE_EN
    ,
    input  logic                 pal_we,
    input  logic [3:0]           pal_addr,
    input  logic [7:0]           pal_data
`endif
);

    localparam int IDX_W     = 32;
    localparam int PIX_LIMIT = NUM_COLUMNS * NUM_ROWS;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int ENTRY_W   = FB_ADDR_W + 8;

    // ---------------- stage 1: index reconstruction ----------------
    logic             accept;
    logic [IDX_W-1:0] index_d;
    logic             sat_d;

    logic             s1_valid_q;
    logic [IDX_W-1:0] s1_index_q;
    logic             s1_sat_q;
    logic [7:0]       s1_key_q;
    logic             s1_last_q;

    assign accept  = in_valid & in_ready;
    assign index_d = IDX_W'(in_solver_addr) * IDX_W'(NUM_SOLVERS) + IDX_W'(in_solver_id);
    assign sat_d   = (in_iter >= ITER_W'(MAX_ITER));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_index_q <= '0;
            s1_sat_q   <= 1'b0;
            s1_key_q   <= '0;
            s1_last_q  <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_index_q <= index_d;
                s1_sat_q   <= sat_d;
                s1_key_q   <= in_iter[7:0];
                s1_last_q  <= in_last;
            end
        end
    end

    // ---------------- colour mapping ----------------
    logic [7:0] colour_d;

`ifdef PALETTE_EN
    logic [7:0] pal_q [16];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                pal_q[i] <= 8'(i * 17);
            end
        end else if (pal_we) begin
            pal_q[pal_addr] <= pal_data;
        end
    end
`endif

    always_comb begin
        colour_d = s1_key_q;
`ifdef PALETTE_EN
        colour_d = pal_q[s1_key_q[3:0]];
`endif
        // "In set" pixels are always black, palette or not.
        if (s1_sat_q) begin
            colour_d = 8'h00;
        end
    end

    // ---------------- stage 2: range check ----------------
    logic             s2_valid_q;
    logic [IDX_W-1:0] s2_index_q;
    logic [7:0]       s2_colour_q;
    logic             s2_last_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid_q  <= 1'b0;
            s2_index_q  <= '0;
            s2_colour_q <= '0;
            s2_last_q   <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_index_q  <= s1_index_q;
                s2_colour_q <= colour_d;
                s2_last_q   <= s1_last_q;
            end
        end
    end

    logic in_range;
    logic push;
    logic drop;

    assign in_range = (s2_index_q < IDX_W'(PIX_LIMIT));
    assign push     = s2_valid_q & in_range;
    assign drop     = s2_valid_q & ~in_range;

    // ---------------- output FIFO (first-word fall-through) ----------------
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [CNT_W-1:0]   wptr_q;
    logic [CNT_W-1:0]   rptr_q;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   fill;
    logic               fifo_empty;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] push_entry;

    assign count      = wptr_q - rptr_q;
    assign fifo_empty = (count == '0);
    assign pop        = ~fifo_empty & wr_ready;
    assign head       = mem_q[rptr_q[PTR_W-1:0]];
    assign push_entry = {FB_ADDR_W'(IDX_W'(FB_BASE) + s2_index_q), s2_colour_q};

    // Beats still in the pipeline are counted as already occupying a slot,
    // so the FIFO can never be pushed while full and the pipeline never stalls.
    assign fill     = count + CNT_W'(s1_valid_q) + CNT_W'(s2_valid_q);
    assign in_ready = ~reset & (fill < CNT_W'(FIFO_DEPTH));

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wptr_q[PTR_W-1:0]] <= push_entry;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    // Storage is not reset, so the outputs are forced to zero when empty.
    assign wr_valid = ~fifo_empty;
    assign wr_addr  = fifo_empty ? '0 : head[ENTRY_W-1:8];
    assign wr_data  = fifo_empty ? '0 : head[7:0];

    // ---------------- drop counter and frame-done ----------------
    logic [15:0] drop_count_q;
    logic [15:0] drop_count_d;
    logic        pending_done_q;
    logic        pending_done_d;
    logic        frame_done_q;
    logic        done_cond;

    assign done_cond = pending_done_q & fifo_empty & ~s1_valid_q & ~s2_valid_q;

    always_comb begin
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_comb begin
        pending_done_d = pending_done_q;
        if (done_cond) begin
            pending_done_d = 1'b0;
        end
        // done_cond needs stage 2 empty, so these two never coincide.
        if (s2_valid_q && s2_last_q) begin
            pending_done_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_count_q   <= '0;
            pending_done_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            drop_count_q   <= drop_count_d;
            pending_done_q <= pending_done_d;
            frame_done_q   <= done_cond;
        end
    end

    assign drop_count = drop_count_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_frame_writer.sv
// tb/tb_frame_writer.sv - self-checking bench for frame_writer against a behavioural pixel model
`timescale 1ns/1ps

module tb_frame_writer;

    localparam int NUM_SOLVERS = 7;
    localparam int NUM_COLUMNS = 99;
    localparam int NUM_ROWS    = 66;
    localparam int ITER_W      = 16;
    localparam int MAX_ITER    = 1000;
    localparam int FB_ADDR_W   = 19;
    localparam int FB_BASE     = 'h200;
    localparam int FIFO_DEPTH  = 8;
    localparam int PIX         = NUM_COLUMNS * NUM_ROWS;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [5:0]           in_solver_id = '0;
    logic [18:0]          in_solver_addr = '0;
    logic [ITER_W-1:0]    in_iter = '0;
    logic                 in_last = 1'b0;
    logic                 wr_valid;
    logic                 wr_ready = 1'b0;
    logic [FB_ADDR_W-1:0] wr_addr;
    logic [7:0]           wr_data;
    logic                 frame_done;
    logic [15:0]          drop_count;
`ifdef PALETTE_EN
    logic                 pal_we = 1'b0;
    logic [3:0]           pal_addr = '0;
    logic [7:0]           pal_data = '0;
`endif

    frame_writer #(
        .NUM_SOLVERS(NUM_SOLVERS), .NUM_COLUMNS(NUM_COLUMNS), .NUM_ROWS(NUM_ROWS),
        .ITER_W(ITER_W), .MAX_ITER(MAX_ITER), .FB_ADDR_W(FB_ADDR_W),
        .FB_BASE(FB_BASE), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_solver_id(in_solver_id), .in_solver_addr(in_solver_addr),
        .in_iter(in_iter), .in_last(in_last),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .drop_count(drop_count)
`ifdef PALETTE_EN
        , .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int ready_mode = 0;      // 0 = hold low, 1 = hold high, 2 = random
    int fd_count = 0;
    int fd_cyc   = -1;
    int stall_viol = 0;
    int exp_drops = 0;
    logic [7:0] pal_model [16];
    logic [FB_ADDR_W+7:0] exp_q [$];
    logic [FB_ADDR_W+7:0] obs_q [$];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        case (ready_mode)
            0:       wr_ready = 1'b0;
            1:       wr_ready = 1'b1;
            default: wr_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Observe the write port between edges; also track hold stability.
    logic                 held = 1'b0;
    logic [FB_ADDR_W-1:0] held_addr;
    logic [7:0]           held_data;
    always @(negedge clock) begin
        #2;
        if (reset) begin
            held = 1'b0;
        end else begin
            if (held && !(wr_valid && wr_addr == held_addr && wr_data == held_data))
                stall_viol++;
            held      = wr_valid && !wr_ready;
            held_addr = wr_addr;
            held_data = wr_data;
            if (wr_valid && wr_ready) obs_q.push_back({wr_addr, wr_data});
            if (frame_done) begin
                fd_count++;
                fd_cyc = cyc;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] colour_of(input int iter);
        if (iter >= MAX_ITER) return 8'h00;
`ifdef PALETTE_EN
        return pal_model[iter % 16];
`else
        return 8'(iter % 256);
`endif
    endfunction

    task automatic model_beat(input int id, input int addr, input int iter);
        int idx;
        idx = addr * NUM_SOLVERS + id;
        if (idx >= PIX) exp_drops++;
        else exp_q.push_back({FB_ADDR_W'(FB_BASE + idx), colour_of(iter)});
    endtask

    task automatic pal_model_reset();
        for (int i = 0; i < 16; i++) pal_model[i] = 8'(i * 17);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send_beat(input int id, input int addr, input int iter, input bit last,
                             output int waited);
        waited = 0;
        @(negedge clock);
        in_valid = 1'b1;
        in_solver_id = 6'(id);
        in_solver_addr = 19'(addr);
        in_iter = 16'(iter);
        in_last = last;
        #1;
        while (!in_ready && waited < 300) begin
            @(negedge clock);
            #1;
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready still 0 after %0d cycles, expected 1", waited);
            in_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1;
            acc_cyc = cyc;
            model_beat(id, addr, iter);
            in_valid = 1'b0;
            in_last = 1'b0;
        end
    endtask

    task automatic wait_drain(output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        while (n < 600) begin
            @(negedge clock);
            #3;
            if (obs_q.size() >= exp_q.size() && !wr_valid) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        repeat (5) @(negedge clock);
        #3;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        obs_q.delete();
        exp_q.delete();
        exp_drops = 0;
        pal_model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        n_checks++; if (wr_valid !== 1'b0) $display("FAIL rst_wr_valid: got %b expected 0", wr_valid); else n_pass++;
        n_checks++; if (wr_addr !== '0) $display("FAIL rst_wr_addr: got %0h expected 0", wr_addr); else n_pass++;
        n_checks++; if (wr_data !== 8'h00) $display("FAIL rst_wr_data: got %0h expected 0", wr_data); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done: got %b expected 0", frame_done); else n_pass++;
        n_checks++; if (drop_count !== 16'h0) $display("FAIL rst_drop_count: got %0d expected 0", drop_count); else n_pass++;
        @(negedge clock);
        reset = 1'b0;
        pal_model_reset();
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready); else n_pass++;
    endtask

    task automatic test_latency();
        int w;
        ready_mode = 1;
        repeat (2) @(negedge clock);
        send_beat(3, 10, 5, 1'b0, w);
        @(negedge clock); #2;
        n_checks++; if (wr_valid !== 1'b0) $display("FAIL lat_k0: wr_valid got %b expected 0", wr_valid); else n_pass++;
        @(negedge clock); #2;
        n_checks++; if (wr_valid !== 1'b0) $display("FAIL lat_k1: wr_valid got %b expected 0", wr_valid); else n_pass++;
        @(negedge clock); #2;
        n_checks++; if (wr_valid !== 1'b1) $display("FAIL lat_k2: wr_valid got %b expected 1", wr_valid); else n_pass++;
        n_checks++; if (wr_addr !== FB_ADDR_W'(FB_BASE + 73)) $display("FAIL lat_addr: got %0h expected %0h", wr_addr, FB_BASE + 73); else n_pass++;
        n_checks++; if (wr_data !== 8'h05) $display("FAIL lat_data: got %0h expected 05", wr_data); else n_pass++;
        repeat (3) @(negedge clock);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_drop_last();
        int w, fd0, k;
        ready_mode = 1;
        fd0 = fd_count;
        send_beat(3, 933, 7, 1'b1, w);
        k = acc_cyc;
        repeat (8) @(negedge clock);
        #3;
        n_checks++; if (drop_count !== 16'(exp_drops)) $display("FAIL drop_count: got %0d expected %0d", drop_count, exp_drops); else n_pass++;
        n_checks++; if (obs_q.size() != 0) $display("FAIL drop_no_write: got %0d writes expected 0", obs_q.size()); else n_pass++;
        n_checks++; if (fd_count != fd0 + 1) $display("FAIL drop_frame_done_count: got %0d expected %0d", fd_count - fd0, 1); else n_pass++;
        n_checks++; if (fd_cyc != k + 3) $display("FAIL drop_frame_done_cycle: got %0d expected %0d", fd_cyc, k + 3); else n_pass++;
    endtask

    task automatic test_colour();
        int w;
        bit ok;
        int iters[5] = '{1000, 1200, 'h1A3, 999, 0};
        ready_mode = 1;
        for (int i = 0; i < 5; i++) send_beat(i % 7, 20 + i, iters[i], i == 4, w);
        wait_drain(ok);
        n_checks++; if (!ok || obs_q.size() != exp_q.size()) $display("FAIL colour_count: got %0d writes expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL colour_%0d: got %0h expected %0h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
`ifndef PALETTE_EN
        if (obs_q.size() > 2) begin
            n_checks++; if (obs_q[2][7:0] !== 8'hA3) $display("FAIL colour_1a3: got %0h expected a3", obs_q[2][7:0]); else n_pass++;
        end
`endif
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_stall();
        int w, wsum, fd0;
        bit ok;
        fd0 = fd_count;
        ready_mode = 0;
        repeat (2) @(negedge clock);
        wsum = 0;
        for (int i = 0; i < 8; i++) begin
            send_beat($urandom_range(0, 6), $urandom_range(0, 900), $urandom_range(0, 1999), 1'b0, w);
            wsum += w;
        end
        n_checks++; if (wsum != 0) $display("FAIL stall_first8_waits: got %0d wait cycles expected 0", wsum); else n_pass++;
        repeat (3) @(negedge clock);
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready_low: got %b expected 0", in_ready); else n_pass++;
        n_checks++; if (wr_valid !== 1'b1) $display("FAIL stall_wr_valid: got %b expected 1", wr_valid); else n_pass++;
        n_checks++; if (obs_q.size() != 0) $display("FAIL stall_no_write: got %0d writes expected 0", obs_q.size()); else n_pass++;
        ready_mode = 1;
        @(negedge clock);
        #2;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_ready_before_pop: got %b expected 0", in_ready); else n_pass++;
        @(posedge clock);
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL stall_ready_after_pop: got %b expected 1", in_ready); else n_pass++;
        for (int i = 8; i < 20; i++)
            send_beat($urandom_range(0, 6), $urandom_range(0, 900), $urandom_range(0, 1999), i == 19, w);
        wait_drain(ok);
        n_checks++; if (!ok || obs_q.size() != 20) $display("FAIL stall_count: got %0d writes expected 20", obs_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL stall_beat_%0d: got %0h expected %0h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (fd_count != fd0 + 1) $display("FAIL stall_frame_done: got %0d pulses expected 1", fd_count - fd0); else n_pass++;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        int w, fd0, id, iter;
        bit ok;
        fd0 = fd_count;
        ready_mode = 2;
        for (int i = 0; i < 150; i++) begin
            id = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 6);
            case ($urandom_range(0, 2))
                0:       iter = $urandom_range(0, 255);
                1:       iter = $urandom_range(256, 999);
                default: iter = $urandom_range(1000, 65535);
            endcase
            send_beat(id, $urandom_range(0, 940), iter, i == 149, w);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        wait_drain(ok);
        n_checks++; if (!ok || obs_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d writes expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL rand_beat_%0d: got %0h expected %0h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (drop_count !== 16'(exp_drops)) $display("FAIL rand_drop_count: got %0d expected %0d", drop_count, exp_drops); else n_pass++;
        n_checks++; if (fd_count != fd0 + 1) $display("FAIL rand_frame_done: got %0d pulses expected 1", fd_count - fd0); else n_pass++;
        n_checks++; if (stall_viol != 0) $display("FAIL hold_stability: got %0d changes while stalled expected 0", stall_viol); else n_pass++;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_midframe();
        int w, fd0;
        bit ok;
        ready_mode = 0;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 5; i++) send_beat(i, 100 + i, 50 + i, i == 4, w);
        repeat (3) @(negedge clock);
        #2;
        fd0 = fd_count;
        reset = 1'b1;
        #1;
        n_checks++; if (wr_valid !== 1'b0) $display("FAIL midrst_wr_valid: got %b expected 0", wr_valid); else n_pass++;
        n_checks++; if (wr_addr !== '0) $display("FAIL midrst_wr_addr: got %0h expected 0", wr_addr); else n_pass++;
        n_checks++; if (drop_count !== 16'h0) $display("FAIL midrst_drop_count: got %0d expected 0", drop_count); else n_pass++;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        obs_q.delete();
        exp_q.delete();
        exp_drops = 0;
        pal_model_reset();
        repeat (6) @(negedge clock);
        #3;
        n_checks++; if (fd_count != fd0) $display("FAIL midrst_no_frame_done: got %0d pulses expected 0", fd_count - fd0); else n_pass++;
        n_checks++; if (wr_valid !== 1'b0) $display("FAIL midrst_empty: wr_valid got %b expected 0", wr_valid); else n_pass++;
        ready_mode = 1;
        for (int i = 0; i < 4; i++) send_beat(6 - i, 300 + 2 * i, 17 * i + 3, i == 3, w);
        wait_drain(ok);
        n_checks++; if (!ok || obs_q.size() != 4) $display("FAIL midrst_fresh_count: got %0d writes expected 4", obs_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL midrst_fresh_%0d: got %0h expected %0h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (fd_count != fd0 + 1) $display("FAIL midrst_fresh_frame_done: got %0d pulses expected 1", fd_count - fd0); else n_pass++;
        obs_q.delete();
        exp_q.delete();
    endtask

`ifdef PALETTE_EN
    task automatic test_palette();
        int w;
        bit ok;
        ready_mode = 1;
        @(negedge clock);
        pal_we = 1'b1; pal_addr = 4'd2; pal_data = 8'hE0;
        @(negedge clock);
        pal_we = 1'b0;
        pal_model[2] = 8'hE0;
        send_beat(1, 40, 'h12, 1'b1, w);
        wait_drain(ok);
        n_checks++; if (!ok || obs_q.size() != 1 || obs_q[0][7:0] !== 8'hE0) $display("FAIL pal_written: got %0d writes data %0h expected 1 write e0", obs_q.size(), (obs_q.size() > 0) ? obs_q[0][7:0] : 8'h00); else n_pass++;
        do_reset();
        send_beat(1, 40, 'h12, 1'b1, w);
        wait_drain(ok);
        n_checks++; if (!ok || obs_q.size() != 1 || obs_q[0][7:0] !== 8'h22) $display("FAIL pal_default: got %0d writes data %0h expected 1 write 22", obs_q.size(), (obs_q.size() > 0) ? obs_q[0][7:0] : 8'h00); else n_pass++;
        obs_q.delete();
        exp_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_drop_last();
        test_colour();
        test_stall();
        test_random();
        test_reset_midframe();
`ifdef PALETTE_EN
        test_palette();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
